camara_sccb_config: RTL
=======================

Name: camara_sccb_config

Overview:
- Power-up and configuration sequencer for the Camara pixel-capture block and its OV7670-class sensor.
- Drives the sensor hard reset (Reset) and power-down (PWDN) lines through the power-up sequence.
- Then writes a register table to the sensor over the 3-phase SCCB write protocol: device ID, register address, data.
- Raises done when the table is written, and gates Camara capture until then.

Parameters:
- CLK_HZ, 100_000_000: system clock frequency in Hz. A 10 ns clk period is 100 MHz.
- SCCB_HZ, 100_000: SIOC frequency in Hz.
- DEV_ID, 8'h42: SCCB write address of the sensor.
- N_REGS, 16: number of table entries. Index width is clog2(N_REGS).
- RST_HOLD_CYC, 1000: number of clk cycles that cam_reset is held low.
- BOOT_WAIT_CYC, 100_000: clk cycles to wait after reset release. The same wait follows a software-reset (COM7) write.

Ports:
- clk  in  1  system clock; all logic runs on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that re-runs the full sequence. Ignored while busy.
- busy  out  1  high while the sequence runs.
- done  out  1  high after the table completes. Cleared by start or rst_n.
- cam_reset  out  1  to sensor Reset pin, active low.
- cam_pwdn  out  1  to sensor PWDN pin. Held 0 (powered) except during reset.
- sioc  out  1  SCCB clock.
- siod_o  out  1  SCCB data value.
- siod_oe  out  1  1 = drive siod_o; 0 = release the line (pad pull-up).
- reg_idx  out  clog2(N_REGS)  index of the entry being written; for debug.

Behaviour:
- Reset values (async, rst_n=0): state=CAM_RST, busy=1, done=0, cam_reset=0, cam_pwdn=1, sioc=1, siod_o=1, siod_oe=1, reg_idx=0, all counters=0. Sequence starts automatically when rst_n is released.
- Quarter tick: DIV = CLK_HZ/(4*SCCB_HZ), default 250. Tick counter runs only in SCCB states. qtr (0..3) advances once per tick.
- Bit frame, 4 quarters:
  - q0: sioc=0, siod_o updates to the new bit (MSB first).
  - q1: sioc=0.
  - q2: sioc=1.
  - q3: sioc=1.
- FSM:
  - CAM_RST: cam_reset=0, cam_pwdn=1 for RST_HOLD_CYC cycles. Then cam_reset=1, cam_pwdn=0 -> BOOT_WAIT.
  - BOOT_WAIT: count BOOT_WAIT_CYC cycles -> LOAD.
  - LOAD: fetch rom[reg_idx].
    - Entry 16'hFFFF, or reg_idx==N_REGS -> FINISH.
    - Otherwise build shift value {DEV_ID, addr, data} (24 bits) -> START.
  - START: sioc=1, siod_o=1 for 2 quarters, then siod_o=0 for 2 quarters -> BITS.
  - BITS: 27 bit frames, as 3 bytes each followed by a 9th "don't-care" frame.
    - In the 9th frame siod_oe=0 and ACK is not sampled.
    - After the 27th frame -> STOP.
  - STOP: q0 sioc=0, siod_o=0; q1 sioc=1; q2 and q3 siod_o=1 -> GAP.
  - GAP: 4 quarters idle with sioc=1, siod_o=1.
    - If addr==8'h12 and data[7]=1 (COM7 soft reset), wait BOOT_WAIT_CYC.
    - Then reg_idx+1 -> LOAD.
  - FINISH: busy=0, done=1, sioc=1, siod_oe=1, siod_o=1 -> IDLE.
  - IDLE: hold outputs. start=1 -> CAM_RST with reg_idx=0, done=0, busy=1.
- Output glitches: sioc and siod are registered outputs with no combinational glitches. siod changes only while sioc=0, except in the start and stop conditions.
- start while busy: ignored, no restart.
- rst_n asserted mid-transfer: all outputs take their reset values immediately. The partial SCCB frame is abandoned; the bus returns high and the sensor is hard-reset anyway.
- Arithmetic: all counters are unsigned and sized to clog2 of their maximum count. A counter saturates at terminal count only for one cycle before its state transition.

Decomposition:
- Package camara_pkg holds:
  - the FSM state enum;
  - SCCB_TERM = 16'hFFFF;
  - COM7_ADDR = 8'h12;
  - the bit-frame count of 27.
- One sub-module, camara_reg_rom:
  - combinational case ROM, idx in -> 16-bit {addr, data} out;
  - entry 0 is {8'h12, 8'h80}, followed by the RGB565/QVGA settings;
  - terminated by 16'hFFFF.

Test Plan (bench parameters: CLK_HZ=4_000_000, SCCB_HZ=1_000_000 so DIV=1, RST_HOLD_CYC=10, BOOT_WAIT_CYC=20):
- Power-up: release rst_n at t0 -> cam_reset=0, cam_pwdn=1 for 10 cycles, then cam_reset=1, cam_pwdn=0; first SCCB start after 20 more cycles; busy=1 throughout.
- Single entry {8'h3A, 8'h04}: bus monitor decodes the start condition, bytes 42/3A/04 with siod_oe=0 on every 9th frame, then the stop condition. siod is stable whenever sioc=1, except at start and stop.
- COM7 entry {8'h12, 8'h80}: the gap after its stop lasts 4 quarters + 20 cycles before the next start. Any other entry has a 4-quarter gap only.
- Table of 3 entries then 16'hFFFF: exactly 3 transactions; done=1, busy=0 one cycle after the last GAP; reg_idx=3.
- start pulse in IDLE -> done=0 next cycle, cam_reset=0 again, full sequence repeats. start pulse while busy -> no effect.
- rst_n low during the second byte -> sioc=1, siod_o=1, siod_oe=1, cam_reset=0 in the same cycle (async). After release the sequence restarts from reg_idx=0.

Source files
------------

// File: rtl/camara_pkg.sv
// Shared types and constants for the Camara sensor power-up / SCCB configuration sequencer.
package camara_pkg;

    typedef enum logic [3:0] {
        StCamRst,
        StBootWait,
        StLoad,
        StStart,
        StBits,
        StStop,
        StGap,
        StFinish,
        StIdle
    } state_e;

    localparam logic [15:0] SCCB_TERM = 16'hFFFF;
    localparam logic [7:0]  COM7_ADDR = 8'h12;
    localparam int unsigned N_FRAMES  = 27;

    // Every 9th frame of a transfer is the don't-care (ACK) slot.
    function automatic logic is_ack_frame(input logic [4:0] n);
        return (n == 5'd8) || (n == 5'd17) || (n == 5'd26);
    endfunction

endpackage

// File: rtl/camara_sccb_config_if.sv
// Control/status and SCCB pin bundle between the sequencer and its surroundings.
interface camara_sccb_config_if #(
    parameter int unsigned IdxW = 4
);
    logic            start;
    logic            busy;
    logic            done;
    logic            cam_reset;
    logic            cam_pwdn;
    logic            sioc;
    logic            siod_o;
    logic            siod_oe;
    logic [IdxW-1:0] reg_idx;

    modport master (
        input  start,
        output busy, done, cam_reset, cam_pwdn, sioc, siod_o, siod_oe, reg_idx
    );

    modport slave (
        output start,
        input  busy, done, cam_reset, cam_pwdn, sioc, siod_o, siod_oe, reg_idx
    );
endinterface

// File: rtl/camara_reg_rom.sv
// Sensor register table: {addr, data} per entry, terminated by SCCB_TERM.
module camara_reg_rom
    import camara_pkg::*;
#(
    parameter int unsigned IdxW = 4
) (
    input  logic [IdxW-1:0] idx_i,
    output logic [15:0]     data_o
);

    always_comb begin
        data_o = SCCB_TERM;
        case (idx_i)
            IdxW'(0): data_o = {COM7_ADDR, 8'h80};  // soft reset, needs boot wait afterwards
            IdxW'(1): data_o = 16'h3A04;            // TSLB
            IdxW'(2): data_o = 16'h40D0;            // COM15: RGB565, full range
            default:  data_o = SCCB_TERM;
        endcase
    end

endmodule

// File: rtl/camara_sccb_config.sv
// Sensor power-up sequencer followed by a 3-phase SCCB write of the register table.
module camara_sccb_config
    import camara_pkg::*;
#(
    parameter int unsigned CLK_HZ        = 100_000_000,
    parameter int unsigned SCCB_HZ       = 100_000,
    parameter logic [7:0]  DEV_ID        = 8'h42,
    parameter int unsigned N_REGS        = 16,
    parameter int unsigned RST_HOLD_CYC  = 1000,
    parameter int unsigned BOOT_WAIT_CYC = 100_000
) (
    input logic             clk,
    input logic             rst_n,
    camara_sccb_config_if.master bus
);

    localparam int unsigned Div    = CLK_HZ / (4 * SCCB_HZ);
    localparam int unsigned DivW   = (Div > 1) ? $clog2(Div) : 1;
    localparam int unsigned IdxW   = (N_REGS > 1) ? $clog2(N_REGS) : 1;
    localparam int unsigned CycMax = (RST_HOLD_CYC > BOOT_WAIT_CYC) ? RST_HOLD_CYC : BOOT_WAIT_CYC;
    localparam int unsigned CycW   = (CycMax > 1) ? $clog2(CycMax) : 1;

    state_e           state_q, state_d;
    logic [CycW-1:0]  cyc_q, cyc_d;
    logic [DivW-1:0]  tick_q, tick_d;
    logic [1:0]       qtr_q, qtr_d;
    logic [4:0]       bit_q, bit_d;
    logic [23:0]      shift_q, shift_d;
    logic [IdxW:0]    idx_q, idx_d;  // one extra bit so N_REGS itself is representable
    logic             busy_q, busy_d, done_q, done_d;
    logic             cam_reset_q, cam_reset_d, cam_pwdn_q, cam_pwdn_d;
    logic             sioc_q, sioc_d, siod_q, siod_d, oe_q, oe_d;

    logic [15:0] rom_data;
    logic        sccb, tick, frame_end, com7;

    camara_reg_rom #(
        .IdxW (IdxW)
    ) u_rom (
        .idx_i  (idx_q[IdxW-1:0]),
        .data_o (rom_data)
    );

    assign sccb      = state_q inside {StStart, StBits, StStop, StGap};
    assign tick      = (tick_q == DivW'(Div - 1));
    assign frame_end = sccb && tick && (qtr_q == 2'd3);
    assign com7      = (rom_data[15:8] == COM7_ADDR) && rom_data[7];

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        tick_d  = '0;
        qtr_d   = '0;
        bit_d   = bit_q;
        shift_d = shift_q;
        idx_d   = idx_q;

        if (sccb) begin
            tick_d = tick ? '0 : tick_q + DivW'(1);
            qtr_d  = tick ? qtr_q + 2'd1 : qtr_q;
        end

        unique case (state_q)
            StCamRst: begin
                if (cyc_q == CycW'(RST_HOLD_CYC - 1)) begin
                    state_d = StBootWait;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + CycW'(1);
                end
            end
            StBootWait: begin
                if (cyc_q == CycW'(BOOT_WAIT_CYC - 1)) begin
                    state_d = StLoad;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + CycW'(1);
                end
            end
            StLoad: begin
                if (idx_q == (IdxW + 1)'(N_REGS) || rom_data == SCCB_TERM) begin
                    state_d = StFinish;
                end else begin
                    shift_d = {DEV_ID, rom_data};
                    state_d = StStart;
                end
            end
            StStart: begin
                if (frame_end) begin
                    state_d = StBits;
                    bit_d   = '0;
                end
            end
            StBits: begin
                if (frame_end) begin
                    if (!is_ack_frame(bit_q)) shift_d = {shift_q[22:0], 1'b0};
                    if (bit_q == 5'(N_FRAMES - 1)) state_d = StStop;
                    else                            bit_d   = bit_q + 5'd1;
                end
            end
            StStop: begin
                if (frame_end) state_d = StGap;
            end
            StGap: begin
                if (frame_end) begin
                    idx_d   = idx_q + (IdxW + 1)'(1);
                    cyc_d   = '0;
                    state_d = com7 ? StBootWait : StLoad;
                end
            end
            StFinish, StIdle: begin
                if (bus.start) begin
                    state_d = StCamRst;
                    idx_d   = '0;
                    cyc_d   = '0;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StCamRst;
        endcase
    end

    // Outputs are decoded from next-state values so they register in step with the FSM.
    always_comb begin
        busy_d      = 1'b1;
        done_d      = 1'b0;
        cam_reset_d = 1'b1;
        cam_pwdn_d  = 1'b0;
        sioc_d      = 1'b1;
        siod_d      = 1'b1;
        oe_d        = 1'b1;
        unique case (state_d)
            StCamRst: begin
                cam_reset_d = 1'b0;
                cam_pwdn_d  = 1'b1;
            end
            StStart: siod_d = ~qtr_d[1];
            StBits: begin
                sioc_d = qtr_d[1];
                oe_d   = ~is_ack_frame(bit_d);
                siod_d = is_ack_frame(bit_d) ? 1'b1 : shift_d[23];
            end
            StStop: begin
                sioc_d = (qtr_d != 2'd0);
                siod_d = qtr_d[1];
            end
            StFinish, StIdle: begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StCamRst;
            cyc_q       <= '0;
            tick_q      <= '0;
            qtr_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            idx_q       <= '0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            cam_reset_q <= 1'b0;
            cam_pwdn_q  <= 1'b1;
            sioc_q      <= 1'b1;
            siod_q      <= 1'b1;
            oe_q        <= 1'b1;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            tick_q      <= tick_d;
            qtr_q       <= qtr_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            idx_q       <= idx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cam_reset_q <= cam_reset_d;
            cam_pwdn_q  <= cam_pwdn_d;
            sioc_q      <= sioc_d;
            siod_q      <= siod_d;
            oe_q        <= oe_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.cam_reset = cam_reset_q;
    assign bus.cam_pwdn  = cam_pwdn_q;
    assign bus.sioc      = sioc_q;
    assign bus.siod_o    = siod_q;
    assign bus.siod_oe   = oe_q;
    assign bus.reg_idx   = idx_q[IdxW-1:0];

endmodule
